// File: rtl/kpix_cmd_pkg.sv
// Shared definitions for the KPIX command controller: FSM encoding, frame
// geometry and the header/parity helpers used by the TX path.
`timescale 1ns/1ps
package kpix_cmd_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_GAP   = 3'd6;

    // Frame geometry
    localparam int HDR_ADDR_W = 7;
    localparam int HDR_BITS   = 11;
    localparam int DPAR_BITS  = 1;

    // Header field positions (bit 10 is transmitted first)
    localparam int HDR_START_POS = 10;
    localparam int HDR_CMD_POS   = 9;
    localparam int HDR_WR_POS    = 8;
    localparam int HDR_ADDR_MSB  = 7;
    localparam int HDR_ADDR_LSB  = 1;
    localparam int HDR_PAR_POS   = 0;

    // XOR reduction; callers zero-extend narrower vectors
    function automatic logic kpix_par(input logic [63:0] v);
        return ^v;
    endfunction

    // Build the 11-bit header with even parity over cmd, write and addr
    function automatic logic [HDR_BITS-1:0] kpix_hdr(input logic cmd,
                                                     input logic wr,
                                                     input logic [HDR_ADDR_W-1:0] addr);
        logic [HDR_BITS-1:0] h;
        h                             = '0;
        h[HDR_START_POS]              = 1'b1;
        h[HDR_CMD_POS]                = cmd;
        h[HDR_WR_POS]                 = wr;
        h[HDR_ADDR_MSB:HDR_ADDR_LSB]  = addr;
        h[HDR_PAR_POS]                = kpix_par(64'({cmd, wr, addr}));
        return h;
    endfunction

endpackage

// File: rtl/kpix_frame_shift.sv
// Loadable MSB-first shift register with a down-counting bit counter.
// The counter stops at zero so the owner can detect the final bit (count==1).
`timescale 1ns/1ps
module kpix_frame_shift #(
    parameter int W  = 44,
    parameter int CW = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_val,
    input  logic [CW-1:0] i_load_cnt,
    input  logic          i_shift,
    input  logic          i_sin,
    output logic [W-1:0]  o_q,
    output logic [CW-1:0] o_cnt
);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;

    // Load has priority over shift; reset clears the register so a serial
    // output driven from its MSB drops to 0 immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_load_val;
            r_cnt <= i_load_cnt;
        end else if (i_shift) begin
            r_sr <= {r_sr[W-2:0], i_sin};
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_q   = r_sr;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/kpix_cmd_ctrl.sv
// KPIX command controller: accepts one host request at a time, serializes it
// on command_c and, for reads, deserializes the reply from rdback_p.
`timescale 1ns/1ps
module kpix_cmd_ctrl
    import kpix_cmd_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4095,
    parameter int GAP     = 4
) (
    input  logic              ext_clk,
    input  logic              reset_c,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_cmd,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              command_c,
    input  logic              rdback_p
);

    // Whole write frame lives in one shifter: header, data, data parity
    localparam int RX_W  = DATA_W + DPAR_BITS;
    localparam int TX_W  = HDR_BITS + RX_W;
    localparam int TXC_W = $clog2(TX_W + 1);
    localparam int RXC_W = $clog2(RX_W + 1);
    localparam int WC_W  = $clog2(TIMEOUT + 1);
    localparam int GC_W  = $clog2(GAP + 1);   // GAP must be at least 1

    logic [2:0]        r_state, w_state_nxt;
    logic              r_wr, r_rd;
    logic              r_sync1, r_sync2;
    logic [WC_W-1:0]   r_wcnt;
    logic [GC_W-1:0]   r_gcnt;
    logic              r_rsp_valid, r_rsp_perr, r_rsp_tmo;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_accept, w_is_wr;
    logic [RX_W-1:0]   w_tx_tail;
    logic [TX_W-1:0]   w_tx_q;
    logic [TXC_W-1:0]  w_tx_cnt, w_hdr_last;
    logic [DATA_W-1:0] w_rx_q;
    logic [RXC_W-1:0]  w_rx_cnt;
    logic              w_to_done, w_rd_done, w_tmo;
    logic              w_unused;

    assign w_accept   = req_valid & (r_state == ST_IDLE);
    assign w_is_wr    = ~req_cmd & req_write;
    assign w_tx_tail  = w_is_wr ? {req_wdata, kpix_par(64'(req_wdata))} : '0;
    // Header ends with RX_W bits still queued for a write, or with the last bit otherwise
    assign w_hdr_last = r_wr ? TXC_W'(RX_W + 1) : TXC_W'(1);

    kpix_frame_shift #(.W(TX_W), .CW(TXC_W)) u_tx (
        .i_clk      (ext_clk),
        .i_rst_n    (reset_c),
        .i_load     (w_accept),
        .i_load_val ({kpix_hdr(req_cmd, w_is_wr, req_addr), w_tx_tail}),
        .i_load_cnt (w_is_wr ? TXC_W'(TX_W) : TXC_W'(HDR_BITS)),
        .i_shift    ((r_state == ST_HDR) || (r_state == ST_WDATA)),
        .i_sin      (1'b0),
        .o_q        (w_tx_q),
        .o_cnt      (w_tx_cnt)
    );

    kpix_frame_shift #(.W(DATA_W), .CW(RXC_W)) u_rx (
        .i_clk      (ext_clk),
        .i_rst_n    (reset_c),
        .i_load     ((r_state == ST_WAIT) && r_sync2),
        .i_load_val ('0),
        .i_load_cnt (RXC_W'(RX_W)),
        .i_shift    (r_state == ST_RDATA),
        .i_sin      (r_sync2),
        .o_q        (w_rx_q),
        .o_cnt      (w_rx_cnt)
    );

    // Next-state logic; a start bit takes precedence over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_rd_done   = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE:  if (req_valid) w_state_nxt = ST_HDR;
            ST_HDR:   if (w_tx_cnt == w_hdr_last)
                          w_state_nxt = r_wr ? ST_WDATA : (r_rd ? ST_WAIT : ST_DONE);
            ST_WDATA: if (w_tx_cnt == TXC_W'(1)) w_state_nxt = ST_DONE;
            ST_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = ST_RDATA;
                end else if (r_wcnt == WC_W'(TIMEOUT)) begin
                    w_state_nxt = ST_DONE;
                    w_tmo       = 1'b1;
                end
            end
            ST_RDATA: if (w_rx_cnt == RXC_W'(1)) begin
                          w_state_nxt = ST_DONE;
                          w_rd_done   = 1'b1;
                      end
            ST_DONE:  w_state_nxt = ST_GAP;
            ST_GAP:   if (r_gcnt == GC_W'(GAP - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_to_done = (w_state_nxt == ST_DONE);

    // State, frame type, wait/gap counters and reply synchronizer
    always_ff @(posedge ext_clk or negedge reset_c) begin
        if (!reset_c) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_wcnt  <= '0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= rdback_p;
            r_sync2 <= r_sync1;
            if (w_accept) begin
                r_wr <= w_is_wr;
                r_rd <= ~req_cmd & ~req_write;
            end
            r_wcnt <= (r_state == ST_WAIT) ? r_wcnt + WC_W'(1) : '0;
            r_gcnt <= (r_state == ST_GAP)  ? r_gcnt + GC_W'(1) : '0;
        end
    end

    // Response registers: updated on entry to DONE, held until the next DONE.
    // On the last RDATA cycle r_sync2 carries the parity bit.
    always_ff @(posedge ext_clk or negedge reset_c) begin
        if (!reset_c) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_perr  <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_rsp_valid <= w_to_done;
            if (w_to_done) begin
                r_rsp_rdata <= w_rd_done ? w_rx_q : '0;
                r_rsp_perr  <= w_rd_done & kpix_par(64'({w_rx_q, r_sync2}));
                r_rsp_tmo   <= w_tmo;
            end
        end
    end

    // Only the MSB of the TX shifter drives the pad
    assign w_unused    = ^w_tx_q[TX_W-2:0];
    assign command_c   = w_tx_q[TX_W-1];
    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_perr    = r_rsp_perr;
    assign rsp_timeout = r_rsp_tmo;

endmodule

// File: tb/tb_kpix_cmd_ctrl.sv
// Directed bench for kpix_cmd_ctrl: write, command, read (good/bad parity),
// read timeout and reset in the middle of a write frame.
`timescale 1ns/1ps
module tb_kpix_cmd_ctrl;

    logic        ext_clk   = 1'b0;
    logic        reset_c   = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_cmd   = 1'b0;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        rdback_p  = 1'b0;
    logic        req_ready, rsp_valid, rsp_perr, rsp_timeout, busy, command_c;
    logic [31:0] rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    kpix_cmd_ctrl dut (
        .ext_clk     (ext_clk),
        .reset_c     (reset_c),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_perr    (rsp_perr),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .command_c   (command_c),
        .rdback_p    (rdback_p)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and watch the line for up to max_k cycles after acceptance.
    // fbits bits of command_c are gathered into frame; a reply (start bit then
    // the 33 bits of reply) is driven from cycle start_k when start_k > 0.
    task automatic do_req(input logic cmd, input logic wr, input logic [6:0] addr,
                          input logic [31:0] wd, input int fbits, input int start_k,
                          input logic [32:0] reply, input int max_k,
                          output logic [43:0] frame, output int lat, output int nvalid,
                          output int ready_k, output int extra, output logic busy1,
                          output logic [31:0] rdata, output logic perr, output logic tmo);
        frame = '0; lat = -1; nvalid = 0; ready_k = -1; extra = 0; busy1 = 1'b0;
        rdata = '0; perr = 1'b0; tmo = 1'b0;
        @(negedge ext_clk);
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_cmd = cmd; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge ext_clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge ext_clk);
            if (k == 1) busy1 = busy;
            if (k <= fbits) frame = {frame[42:0], command_c};
            else if (command_c) extra++;
            if (rsp_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = k; rdata = rsp_rdata; perr = rsp_perr; tmo = rsp_timeout;
                end
            end
            if (lat > 0 && ready_k < 0 && req_ready) ready_k = k;
            if (start_k > 0 && k >= start_k && k < start_k + 34)
                rdback_p = (k == start_k) ? 1'b1 : reply[33 - (k - start_k)];
            else
                rdback_p = 1'b0;
            if (ready_k > 0 && k > ready_k) break;
        end
        rdback_p = 1'b0;
    endtask

    logic [43:0] frame;
    int          lat, nvalid, ready_k, extra;
    logic        busy1, perr, tmo;
    logic [31:0] rdata;
    int          nv_after_rst, ones_after_rst;

    initial begin
        // Reset state
        repeat (2) @(negedge ext_clk);
        chk("rst_command_c", command_c, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_perr", rsp_perr, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_c = 1'b1;
        repeat (2) @(negedge ext_clk);

        // Register write addr 0x05, data 0xA5A50001
        do_req(1'b0, 1'b1, 7'h05, 32'hA5A50001, 44, 0, 33'h0, 80,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("wr_frame", frame, {11'b1_0_1_0000101_1, 32'hA5A50001, 1'b1});
        chk("wr_busy", busy1, 1'b1);
        chk("wr_latency", lat, 45);
        chk("wr_nvalid", nvalid, 1);
        chk("wr_perr", perr, 1'b0);
        chk("wr_timeout", tmo, 1'b0);
        chk("wr_rdata", rdata, 32'h0);
        chk("wr_ready_after_gap", ready_k, 50);
        chk("wr_idle_line", extra, 0);

        // Command addr 0x02
        do_req(1'b1, 1'b0, 7'h02, 32'h0, 11, 0, 33'h0, 40,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("cmd_frame", frame, {33'h0, 11'b1_1_0_0000010_0});
        chk("cmd_latency", lat, 12);
        chk("cmd_rdata", rdata, 32'h0);
        chk("cmd_ready_after_gap", ready_k, 17);
        chk("cmd_idle_line", extra, 0);

        // Read addr 0x01, start bit driven 5 cycles after header, good parity
        do_req(1'b0, 1'b0, 7'h01, 32'h0, 11, 16, {32'h12345678, 1'b1}, 100,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("rd_frame", frame, {33'h0, 11'b1_0_0_0000001_1});
        chk("rd_latency", lat, 52);
        chk("rd_rdata", rdata, 32'h12345678);
        chk("rd_perr", perr, 1'b0);
        chk("rd_timeout", tmo, 1'b0);
        chk("rd_rdata_hold", rsp_rdata, 32'h12345678);

        // Same read, parity bit flipped
        do_req(1'b0, 1'b0, 7'h01, 32'h0, 11, 16, {32'h12345678, 1'b0}, 100,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("rdp_latency", lat, 52);
        chk("rdp_rdata", rdata, 32'h12345678);
        chk("rdp_perr", perr, 1'b1);

        // Read with no reply: timeout after counter reaches 4095
        do_req(1'b0, 1'b0, 7'h01, 32'h0, 11, 0, 33'h0, 4200,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("to_latency", lat, 12 + 4096);
        chk("to_timeout", tmo, 1'b1);
        chk("to_rdata", rdata, 32'h0);
        chk("to_perr", perr, 1'b0);
        chk("to_nvalid", nvalid, 1);

        // Normal command accepted after timeout
        do_req(1'b1, 1'b0, 7'h02, 32'h0, 11, 0, 33'h0, 40,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("to_next_frame", frame, {33'h0, 11'b1_1_0_0000010_0});
        chk("to_next_latency", lat, 12);
        chk("to_next_timeout_clr", tmo, 1'b0);

        // Reset in the middle of WDATA (cycle 12 carries wdata[31] = 1)
        @(negedge ext_clk);
        req_valid = 1'b1; req_cmd = 1'b0; req_write = 1'b1; req_addr = 7'h05;
        req_wdata = 32'hA5A50001;
        @(posedge ext_clk);
        #1 req_valid = 1'b0;
        repeat (12) @(negedge ext_clk);
        chk("mid_wdata_bit", command_c, 1'b1);
        reset_c = 1'b0;
        #1;
        chk("mid_rst_command_c", command_c, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(negedge ext_clk);
        reset_c = 1'b1;
        nv_after_rst = 0; ones_after_rst = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge ext_clk);
            if (rsp_valid) nv_after_rst++;
            if (command_c) ones_after_rst++;
        end
        chk("mid_rst_no_rsp", nv_after_rst, 0);
        chk("mid_rst_line_idle", ones_after_rst, 0);
        chk("mid_rst_ready", req_ready, 1'b1);
        do_req(1'b1, 1'b0, 7'h02, 32'h0, 11, 0, 33'h0, 40,
               frame, lat, nvalid, ready_k, extra, busy1, rdata, perr, tmo);
        chk("post_rst_frame", frame, {33'h0, 11'b1_1_0_0000010_0});
        chk("post_rst_latency", lat, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
